// File: rtl/uart_pkg.sv
// uart_pkg -- constants shared by uart_rx, uart_tx and uart_tx_arbiter.
//
// Contents:
//   DEF_CLK_FREQ, DEF_UART_BPS : default system clock and baud rate
//   UART_FRAME_BITS            : start + 8 data + stop
//   arb_state_t                : arbiter FSM encoding (IDLE=0, WAIT=1)
//   baud_cnt_max()             : clocks per bit. Every UART block derives
//                                its bit timing from this one function, so
//                                they all agree on the same numbers.
package uart_pkg;

  localparam int DEF_CLK_FREQ    = 50_000_000;
  localparam int DEF_UART_BPS    = 9600;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// uart_arb_pick -- combinational winner selector for uart_tx_arbiter.
//
// Ports:
//   req    [NUM_REQ]  active request vector
//   ptr    [ID_W]     index of the last granted requester
//   winner [ID_W]     selected requester (0 when valid is low)
//   valid             at least one request is active
//
// Build option UART_ARB_PRIORITY_EN:
//   defined   -> fixed priority. The lowest active index wins and ptr is ignored.
//   undefined -> round-robin. The search starts at ptr+1 and wraps modulo
//                NUM_REQ, so ptr itself is considered last.
module uart_arb_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;

`ifdef UART_ARB_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest set index is the last to be written.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'(i);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
`else
  // Visit ptr+1, ptr+2, ..., ptr in order. The first active request found wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one uart_tx between NUM_REQ byte sources.
//
// Ports:
//   sys_clk, sys_rst_n  clock and synchronous active-low reset
//   req      [NUM_REQ]    level request per requester
//   req_data [8*NUM_REQ]  byte of requester k on bits [8k+7:8k]
//   gnt      [NUM_REQ]    one-cycle pulse: that requester's byte was taken
//   pi_data  [8]          byte handed to uart_tx
//   pi_flag               one-cycle strobe to uart_tx, coincident with gnt
//   tx_busy               high from the grant cycle until back in IDLE
//   gnt_id   [ID_W]       index of the last granted requester
//
// Handshake: a requester holds req high with valid data until it sees its
// gnt bit. The byte is captured on the grant edge. From the following
// cycle the requester may change data or drop req. A request dropped
// before it is granted is never served.
//
// After each grant the arbiter spends FRAME_CYCLES clocks in WAIT. During
// that time it ignores req while uart_tx shifts the frame out.
//
// Build option UART_ARB_PRIORITY_EN (see uart_arb_pick): fixed-priority
// selection instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int UART_BPS   = DEF_UART_BPS,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [7:0]                 pi_data,
  output logic                       pi_flag,
  output logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int FRAME_CYCLES = BAUD_CNT_MAX * FRAME_BITS + GAP_CYCLES;
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int ID_W         = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  // With the pointer on the top index, requester 0 is searched first after reset.
  localparam logic [ID_W-1:0]  ID_RESET = ID_W'(NUM_REQ - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [7:0]       pi_data_nxt;
  logic             pi_flag_nxt;
  logic             tx_busy_nxt;
  logic [ID_W-1:0]  gnt_id_nxt;

  logic [ID_W-1:0]  pick_winner;
  logic             pick_valid;

  logic [7:0] req_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = req_data[8*k +: 8];
  end

  uart_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (gnt_id),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      gnt       <= '0;
      pi_data   <= 8'h00;
      pi_flag   <= 1'b0;
      tx_busy   <= 1'b0;
      gnt_id    <= ID_RESET;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      gnt       <= gnt_nxt;
      pi_data   <= pi_data_nxt;
      pi_flag   <= pi_flag_nxt;
      tx_busy   <= tx_busy_nxt;
      gnt_id    <= gnt_id_nxt;
    end
  end

  // Strobes default to 0, so gnt and pi_flag last exactly one cycle.
  // pi_data and gnt_id keep their values until the next grant.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    gnt_nxt       = '0;
    pi_data_nxt   = pi_data;
    pi_flag_nxt   = 1'b0;
    tx_busy_nxt   = tx_busy;
    gnt_id_nxt    = gnt_id;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nxt[pick_winner] = 1'b1;
          pi_data_nxt          = req_bytes[pick_winner];
          pi_flag_nxt          = 1'b1;
          gnt_id_nxt           = pick_winner;
          tx_busy_nxt          = 1'b1;
          frame_cnt_nxt        = '0;
          state_nxt            = WAIT;
        end
      end
      WAIT: begin
        // The counter saturates at CNT_LAST rather than wrapping. It is
        // cleared again on the next grant.
        if (frame_cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          tx_busy_nxt = 1'b0;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
